// File: rtl/pres_pkg.sv
// Shared zone encodings and debounce FSM states for the pressure conditioner
// and for the downstream compressor alternator bench.
package pres_pkg;

  typedef enum logic [1:0] {
    ZN = 2'd0,  // normal band
    ZH = 2'd1,  // high
    ZL = 2'd2,  // low
    ZV = 2'd3   // very low
  } zone_e;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } deb_state_e;

endpackage

// File: rtl/pres_zone_decode.sv
// Combinational target-zone decode: given the committed zone and the current
// sample, returns the zone the debouncer should qualify toward. Exit
// thresholds apply the hysteresis margin with saturation (no wrap).
module pres_zone_decode
  import pres_pkg::*;
#(
  parameter int W       = 8,
  parameter int TH_HIGH = 200,
  parameter int TH_LOW  = 80,
  parameter int TH_VLOW = 40,
  parameter int HYST    = 10
) (
  input  zone_e          z,
  input  logic [W-1:0]   pres,
  output zone_e          target
);

  localparam logic [W:0] TH_HIGH_X = TH_HIGH[W:0];
  localparam logic [W:0] TH_LOW_X  = TH_LOW[W:0];
  localparam logic [W:0] TH_VLOW_X = TH_VLOW[W:0];
  localparam logic [W:0] HYST_X    = HYST[W:0];
  localparam logic [W:0] MAX_X     = {1'b0, {W{1'b1}}};

  function automatic logic [W-1:0] sat_sub(input logic [W:0] a, input logic [W:0] b);
    logic [W:0] d;
    d = a - b;
    if (b > a) return '0;
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_add(input logic [W:0] a, input logic [W:0] b);
    logic [W:0] s;
    s = a + b;
    if (s > MAX_X) return {W{1'b1}};
    return s[W-1:0];
  endfunction

  localparam logic [W-1:0] HIGH_EXIT = sat_sub(TH_HIGH_X, HYST_X);
  localparam logic [W-1:0] LOW_EXIT  = sat_add(TH_LOW_X, HYST_X);
  localparam logic [W-1:0] VLOW_EXIT = sat_add(TH_VLOW_X, HYST_X);
  localparam logic [W-1:0] TH_HIGH_W = TH_HIGH_X[W-1:0];
  localparam logic [W-1:0] TH_LOW_W  = TH_LOW_X[W-1:0];
  localparam logic [W-1:0] TH_VLOW_W = TH_VLOW_X[W-1:0];

  zone_e raw;

  // Raw classification plus hysteresis-gated exit from the committed zone
  always_comb begin
    raw = ZN;
    if (pres >= TH_HIGH_W)      raw = ZH;
    else if (pres <= TH_VLOW_W) raw = ZV;
    else if (pres <= TH_LOW_W)  raw = ZL;

    target = z;
    unique case (z)
      ZN: target = raw;
      ZH: if (pres < HIGH_EXIT) target = raw;
      ZL: begin
        if (pres <= TH_VLOW_W)     target = ZV;
        else if (pres > LOW_EXIT)  target = raw;
      end
      ZV: if (pres > VLOW_EXIT) target = raw;
      default: target = ZN;
    endcase
  end

endmodule

// File: rtl/pres_zone_conditioner.sv
// Pressure zone conditioner: classifies samples, debounces zone changes over
// DEB_COUNT consecutive valid samples and drives one-hot PA/PB/PMB flags.
// Optional sensor watchdog enabled by defining SENSOR_FAULT_EN.
module pres_zone_conditioner
  import pres_pkg::*;
#(
  parameter int W         = 8,
  parameter int TH_HIGH   = 200,
  parameter int TH_LOW    = 80,
  parameter int TH_VLOW   = 40,
  parameter int HYST      = 10,
  parameter int DEB_COUNT = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [W-1:0] Pres,
  input  logic         PresValid,
  output logic         PA,
  output logic         PB,
  output logic         PMB,
  output logic         Changed,
  output logic         Fault
);

  localparam int CW = (DEB_COUNT < 2) ? 1 : $clog2(DEB_COUNT + 1);
  localparam logic [CW-1:0] DEB_N = DEB_COUNT[CW-1:0];

  zone_e               z_q, z_d, cand_q, cand_d, target;
  deb_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pa_q, pb_q, pmb_q, changed_q, changed_d;

  pres_zone_decode #(
    .W(W), .TH_HIGH(TH_HIGH), .TH_LOW(TH_LOW), .TH_VLOW(TH_VLOW), .HYST(HYST)
  ) u_decode (
    .z      (z_q),
    .pres   (Pres),
    .target (target)
  );

`ifdef SENSOR_FAULT_EN
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TO_LAST_I = TIMEOUT - 1;
  localparam logic [WDW-1:0] TO_LAST = TO_LAST_I[WDW-1:0];
  logic [WDW-1:0] wd_q, wd_d;
  logic           fault_q, fault_d;
`endif

  // Debounce FSM next state, commit of the qualified candidate, watchdog
  always_comb begin
    z_d       = z_q;
    cand_d    = cand_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;
`ifdef SENSOR_FAULT_EN
    wd_d      = wd_q;
    fault_d   = fault_q;
`endif
    if (PresValid) begin
      if (target == z_q) begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end else begin
        if (state_q == ST_STABLE || target != cand_q) begin
          cand_d  = target;
          cnt_d   = CW'(1);
          state_d = ST_QUALIFY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == DEB_N) begin
          z_d       = cand_d;
          changed_d = 1'b1;
          state_d   = ST_STABLE;
          cnt_d     = '0;
        end
      end
    end
`ifdef SENSOR_FAULT_EN
    // A valid sample clears the fault; a silent sensor forces the normal zone
    if (PresValid) begin
      wd_d    = '0;
      fault_d = 1'b0;
    end else if (!fault_q) begin
      if (wd_q == TO_LAST) begin
        fault_d   = 1'b1;
        wd_d      = '0;
        z_d       = ZN;
        changed_d = (z_q != ZN);
        cand_d    = ZN;
        state_d   = ST_STABLE;
        cnt_d     = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  // State and registered output decodes
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      z_q       <= ZN;
      cand_q    <= ZN;
      state_q   <= ST_STABLE;
      cnt_q     <= '0;
      changed_q <= 1'b0;
      pa_q      <= 1'b0;
      pb_q      <= 1'b0;
      pmb_q     <= 1'b0;
    end else begin
      z_q       <= z_d;
      cand_q    <= cand_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
      pa_q      <= (z_d == ZH);
      pb_q      <= (z_d == ZL);
      pmb_q     <= (z_d == ZV);
    end
  end

`ifdef SENSOR_FAULT_EN
  // Watchdog counter and fault flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end
  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  assign PA      = pa_q;
  assign PB      = pb_q;
  assign PMB     = pmb_q;
  assign Changed = changed_q;

endmodule

// File: tb/tb_pres_zone_conditioner.sv
// Directed bench for pres_zone_conditioner (W=8, thresholds 200/80/40, HYST=10,
// DEB_COUNT=3, TIMEOUT=16). Watchdog sequence is built when SENSOR_FAULT_EN is set.
module tb_pres_zone_conditioner;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Pres = 8'd0;
  logic       PresValid = 1'b0;
  logic       PA, PB, PMB, Changed, Fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [7:0] p;
    logic [3:0] exp;  // {PA, PB, PMB, Changed}
  } vec_t;

  vec_t vecs[$];

  pres_zone_conditioner dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Pres      (Pres),
    .PresValid (PresValid),
    .PA        (PA),
    .PB        (PB),
    .PMB       (PMB),
    .Changed   (Changed),
    .Fault     (Fault)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got {PA,PB,PMB,Chg,Fault}=%b want %b at %0t", name, got, req, $time);
    end
  endtask

  // Drive one cycle on the falling edge and check just after the rising edge
  task automatic step(input logic v, input logic [7:0] p, input logic [3:0] exp,
                      input logic fexp, input string name);
    @(negedge Clk);
    PresValid = v;
    Pres      = p;
    @(posedge Clk);
    #1;
    check(name, {PA, PB, PMB, Changed, Fault}, {exp, fexp});
  endtask

  task automatic add(input logic v, input logic [7:0] p, input int n, input logic [3:0] exp);
    vec_t t;
    t.v = v; t.p = p; t.exp = exp;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask

  task automatic async_reset(input string name);
    @(negedge Clk);
    PresValid = 1'b0;
    #2 Reset_n = 1'b0;
    #1 check(name, {PA, PB, PMB, Changed, Fault}, 5'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    // Stimulus table: hand-computed flags per valid/invalid sample
    add(1, 150, 3, 4'b0000);                 // normal band
    add(1, 210, 2, 4'b0000);
    add(1, 150, 1, 4'b0000);                 // candidate dropped
    add(1, 210, 2, 4'b0000);                 // count restarted
    add(1, 210, 1, 4'b1001);                 // commit high
    add(1, 210, 1, 4'b1000);                 // pulse is one cycle
    add(1, 195, 3, 4'b1000);                 // inside hysteresis
    add(1, 189, 2, 4'b1000);
    add(1, 189, 1, 4'b0001);                 // leave high
    add(1,  30, 2, 4'b0000);
    add(1,  30, 1, 4'b0011);                 // very low
    add(1,  45, 3, 4'b0010);                 // hysteresis holds VLOW
    add(1,  60, 2, 4'b0010);
    add(1,  60, 1, 4'b0101);                 // low
    add(1,  85, 3, 4'b0100);                 // hysteresis holds LOW
    add(1,  91, 2, 4'b0100);
    add(1,  91, 1, 4'b0001);                 // back to normal
    add(1,  80, 2, 4'b0000);
    add(1,  80, 1, 4'b0101);                 // TH_LOW inclusive
    add(1,  90, 3, 4'b0100);                 // TH_LOW+HYST still low
    add(1,  40, 2, 4'b0100);
    add(1,  40, 1, 4'b0011);                 // low -> very low at TH_VLOW
    add(1,  51, 2, 4'b0010);
    add(1,  51, 1, 4'b0101);                 // very low -> low
    add(1,  91, 2, 4'b0100);
    add(1,  91, 1, 4'b0001);
    add(1, 210, 1, 4'b0000);                 // invalid gaps hold state
    add(0,   0, 5, 4'b0000);
    add(1, 210, 1, 4'b0000);
    add(1, 210, 1, 4'b1001);
    add(1, 189, 2, 4'b1000);
    add(1, 189, 1, 4'b0001);
    add(1, 210, 2, 4'b0000);                 // candidate replaced
    add(1,  30, 2, 4'b0000);
    add(1,  30, 1, 4'b0011);
    add(1, 200, 2, 4'b0010);
    add(1, 200, 1, 4'b1001);                 // TH_HIGH inclusive
    add(1, 190, 3, 4'b1000);                 // exactly TH_HIGH-HYST holds

    // Reset state
    #1 check("reset_hold", {PA, PB, PMB, Changed, Fault}, 5'b0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].v, vecs[i].p, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));

    // Async reset while in high zone clears flags immediately
    async_reset("reset_mid_stream");
    step(1, 150, 4'b0000, 1'b0, "post_reset_normal");

    // Reset during QUALIFY discards the partial count
    step(1, 210, 4'b0000, 1'b0, "qual_a");
    step(1, 210, 4'b0000, 1'b0, "qual_b");
    async_reset("reset_mid_qualify");
    step(1, 210, 4'b0000, 1'b0, "requal_1");
    step(1, 210, 4'b0000, 1'b0, "requal_2");
    step(1, 210, 4'b1001, 1'b0, "requal_3");

`ifdef SENSOR_FAULT_EN
    // Watchdog: 16 silent cycles in the high zone
    for (int i = 0; i < 15; i++)
      step(0, 0, 4'b1000, 1'b0, $sformatf("wd_quiet%0d", i));
    step(0, 0, 4'b0001, 1'b1, "wd_fault");
    step(0, 0, 4'b0000, 1'b1, "wd_fault_hold");
    step(1, 210, 4'b0000, 1'b0, "wd_clear");
    step(1, 210, 4'b0000, 1'b0, "wd_requal");
    step(1, 210, 4'b1001, 1'b0, "wd_recommit");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
